bcd_clock_12_24: RTL and testbench

BCD_CLOCK_12_24 -- requirements
Module: bcd_clock_12_24

---
 rtl/bcd_clock_12_24.sv | 197 +++++++++++++++++++
 tb/tb_bcd_clock_12_24.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_clock_12_24.sv
// 24h BCD time-of-day counter with a 12h/24h display mapping and a validated load port.
// Optional alarm comparator is built when BCD_CLOCK_ALARM_EN is defined.
module bcd_clock_12_24 #(
   parameter int TICK_DIV = 50000000,
   parameter int RST_HOUR = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       mode_12h,
   input  logic       set_req,
   input  logic [3:0] set_ht,
   input  logic [3:0] set_hu,
   input  logic [3:0] set_mt,
   input  logic [3:0] set_mu,
   input  logic [3:0] set_st,
   input  logic [3:0] set_su,
   output logic       set_ack,
   output logic       set_err,
   output logic [3:0] bcd_hto,
   output logic [3:0] bcd_huo,
   output logic [3:0] bcd_mt,
   output logic [3:0] bcd_mu,
   output logic [3:0] bcd_st,
   output logic [3:0] bcd_su,
   output logic       pm,
   output logic       sec_pulse
`ifdef BCD_CLOCK_ALARM_EN
   ,
   input  logic [3:0] alarm_ht,
   input  logic [3:0] alarm_hu,
   input  logic [3:0] alarm_mt,
   input  logic [3:0] alarm_mu,
   output logic       alarm_hit
`endif
);

   localparam int            PW        = $clog2(TICK_DIV);
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
   localparam logic [3:0]    RST_HT    = 4'(RST_HOUR / 10);
   localparam logic [3:0]    RST_HU    = 4'(RST_HOUR % 10);

   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    ht_q, ht_d, hu_q, hu_d;
   logic [3:0]    mt_q, mt_d, mu_q, mu_d;
   logic [3:0]    st_q, st_d, su_q, su_d;
   logic          sec_pulse_q, sec_pulse_d;
   logic          set_ack_q, set_ack_d;
   logic          set_err_q, set_err_d;
   logic          tick, set_ok, inc;
   logic [4:0]    h24, h_disp, h_tens;

   // A load must describe a real 24h time; anything else is bounced with set_err.
   assign set_ok = (set_ht <= 4'd2) && (set_hu <= 4'd9) &&
                   ((set_ht != 4'd2) || (set_hu <= 4'd3)) &&
                   (set_mt <= 4'd5) && (set_mu <= 4'd9) &&
                   (set_st <= 4'd5) && (set_su <= 4'd9);

   assign tick = (presc_q == TICK_LAST);

   always_comb begin
      presc_d     = tick ? '0 : presc_q + 1'b1;
      ht_d        = ht_q;
      hu_d        = hu_q;
      mt_d        = mt_q;
      mu_d        = mu_q;
      st_d        = st_q;
      su_d        = su_q;
      sec_pulse_d = 1'b0;
      set_ack_d   = 1'b0;
      set_err_d   = 1'b0;
      inc         = 1'b0;
      if (set_req && set_ok) begin
         // An accepted load swallows a coincident tick and restarts the second.
         ht_d      = set_ht;
         hu_d      = set_hu;
         mt_d      = set_mt;
         mu_d      = set_mu;
         st_d      = set_st;
         su_d      = set_su;
         presc_d   = '0;
         set_ack_d = 1'b1;
      end else begin
         set_err_d = set_req;
         inc       = tick;
      end
      if (inc) begin
         sec_pulse_d = 1'b1;
         if (su_q != 4'd9) begin
            su_d = su_q + 4'd1;
         end else begin
            su_d = 4'd0;
            if (st_q != 4'd5) begin
               st_d = st_q + 4'd1;
            end else begin
               st_d = 4'd0;
               if (mu_q != 4'd9) begin
                  mu_d = mu_q + 4'd1;
               end else begin
                  mu_d = 4'd0;
                  if (mt_q != 4'd5) begin
                     mt_d = mt_q + 4'd1;
                  end else begin
                     mt_d = 4'd0;
                     if ((ht_q == 4'd2) && (hu_q == 4'd3)) begin
                        ht_d = 4'd0;
                        hu_d = 4'd0;
                     end else if (hu_q == 4'd9) begin
                        ht_d = ht_q + 4'd1;
                        hu_d = 4'd0;
                     end else begin
                        hu_d = hu_q + 4'd1;
                     end
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_q     <= '0;
         ht_q        <= RST_HT;
         hu_q        <= RST_HU;
         mt_q        <= 4'd0;
         mu_q        <= 4'd0;
         st_q        <= 4'd0;
         su_q        <= 4'd0;
         sec_pulse_q <= 1'b0;
         set_ack_q   <= 1'b0;
         set_err_q   <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         ht_q        <= ht_d;
         hu_q        <= hu_d;
         mt_q        <= mt_d;
         mu_q        <= mu_d;
         st_q        <= st_d;
         su_q        <= su_d;
         sec_pulse_q <= sec_pulse_d;
         set_ack_q   <= set_ack_d;
         set_err_q   <= set_err_d;
      end
   end

`ifdef BCD_CLOCK_ALARM_EN
   logic alarm_hit_q, alarm_hit_d;

   // Only a counted increment landing on hh:mm:00 fires; loads never do.
   always_comb begin
      alarm_hit_d = inc && (st_d == 4'd0) && (su_d == 4'd0) &&
                    (ht_d == alarm_ht) && (hu_d == alarm_hu) &&
                    (mt_d == alarm_mt) && (mu_d == alarm_mu);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alarm_hit_q <= 1'b0;
      end else begin
         alarm_hit_q <= alarm_hit_d;
      end
   end

   assign alarm_hit = alarm_hit_q;
`endif

   // Display hour is derived combinationally so mode_12h never touches the counters.
   always_comb begin
      h24 = (5'(ht_q) * 5'd10) + 5'(hu_q);
      if (mode_12h && (h24 == 5'd0)) begin
         h_disp = 5'd12;
      end else if (mode_12h && (h24 > 5'd12)) begin
         h_disp = h24 - 5'd12;
      end else begin
         h_disp = h24;
      end
      if (h_disp >= 5'd20) begin
         h_tens = 5'd2;
      end else if (h_disp >= 5'd10) begin
         h_tens = 5'd1;
      end else begin
         h_tens = 5'd0;
      end
   end

   assign bcd_hto   = 4'(h_tens);
   assign bcd_huo   = 4'(h_disp - (h_tens * 5'd10));
   assign bcd_mt    = mt_q;
   assign bcd_mu    = mu_q;
   assign bcd_st    = st_q;
   assign bcd_su    = su_q;
   assign pm        = (h24 >= 5'd12);
   assign sec_pulse = sec_pulse_q;
   assign set_ack   = set_ack_q;
   assign set_err   = set_err_q;

endmodule

// File: tb/tb_bcd_clock_12_24.sv
// Directed bench for bcd_clock_12_24 with TICK_DIV=4, RST_HOUR=0.
// Alarm sequences are included when BCD_CLOCK_ALARM_EN is defined.
module tb_bcd_clock_12_24;

   logic       clk = 1'b0;
   logic       rst_n, mode_12h, set_req;
   logic [3:0] set_ht, set_hu, set_mt, set_mu, set_st, set_su;
   logic       set_ack, set_err, pm, sec_pulse;
   logic [3:0] bcd_hto, bcd_huo, bcd_mt, bcd_mu, bcd_st, bcd_su;
`ifdef BCD_CLOCK_ALARM_EN
   logic [3:0] alarm_ht, alarm_hu, alarm_mt, alarm_mu;
   logic       alarm_hit;
`endif

   int checks = 0;
   int errors = 0;

   bcd_clock_12_24 #(.TICK_DIV(4), .RST_HOUR(0)) dut (
      .clk(clk), .rst_n(rst_n), .mode_12h(mode_12h), .set_req(set_req),
      .set_ht(set_ht), .set_hu(set_hu), .set_mt(set_mt),
      .set_mu(set_mu), .set_st(set_st), .set_su(set_su),
      .set_ack(set_ack), .set_err(set_err),
      .bcd_hto(bcd_hto), .bcd_huo(bcd_huo), .bcd_mt(bcd_mt),
      .bcd_mu(bcd_mu), .bcd_st(bcd_st), .bcd_su(bcd_su),
      .pm(pm), .sec_pulse(sec_pulse)
`ifdef BCD_CLOCK_ALARM_EN
      ,
      .alarm_ht(alarm_ht), .alarm_hu(alarm_hu), .alarm_mt(alarm_mt),
      .alarm_mu(alarm_mu), .alarm_hit(alarm_hit)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        req;
      logic [23:0] set_t;
      logic        m12;
      logic [23:0] exp_t;
      logic [3:0]  exp_f;   // {pm, sec_pulse, set_ack, set_err}
   } vec_t;

   vec_t vecs [16];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_set(input logic [23:0] t);
      {set_ht, set_hu, set_mt, set_mu, set_st, set_su} = t;
      set_req = 1'b1;
   endtask

   task automatic check(input string name, input logic [23:0] exp_t, input logic [3:0] exp_f);
      logic [27:0] got;
      got = {bcd_hto, bcd_huo, bcd_mt, bcd_mu, bcd_st, bcd_su, pm, sec_pulse, set_ack, set_err};
      checks++;
      if (got !== {exp_t, exp_f}) begin
         errors++;
         $display("FAIL %s: got time %h flags %b, expected time %h flags %b",
                  name, got[27:4], got[3:0], exp_t, exp_f);
      end
   endtask

`ifdef BCD_CLOCK_ALARM_EN
   task automatic check_hit(input string name, input logic exp);
      checks++;
      if (alarm_hit !== exp) begin
         errors++;
         $display("FAIL %s: alarm_hit got %b expected %b", name, alarm_hit, exp);
      end
   endtask
`endif

   initial begin
      logic [23:0] et;
      logic        sp;

      vecs[0]  = '{1'b1, 24'h003000, 1'b1, 24'h123000, 4'b0010};
      vecs[1]  = '{1'b1, 24'h120500, 1'b1, 24'h120500, 4'b1010};
      vecs[2]  = '{1'b1, 24'h130000, 1'b1, 24'h010000, 4'b1010};
      vecs[3]  = '{1'b0, 24'h000000, 1'b0, 24'h130000, 4'b1000};
      vecs[4]  = '{1'b1, 24'h240000, 1'b0, 24'h130000, 4'b1001};
      vecs[5]  = '{1'b1, 24'h136A00, 1'b0, 24'h130000, 4'b1001};
      vecs[6]  = '{1'b1, 24'h091530, 1'b0, 24'h091530, 4'b0010};
      vecs[7]  = '{1'b1, 24'h110000, 1'b1, 24'h110000, 4'b0010};
      vecs[8]  = '{1'b1, 24'h235959, 1'b1, 24'h115959, 4'b1010};
      vecs[9]  = '{1'b1, 24'h2A0000, 1'b1, 24'h115959, 4'b1001};
      vecs[10] = '{1'b1, 24'h120060, 1'b1, 24'h115959, 4'b1001};
      vecs[11] = '{1'b1, 24'h120000, 1'b0, 24'h120000, 4'b1010};
      vecs[12] = '{1'b1, 24'h000000, 1'b0, 24'h000000, 4'b0010};
      vecs[13] = '{1'b1, 24'h010000, 1'b1, 24'h010000, 4'b0010};
      vecs[14] = '{1'b1, 24'h194509, 1'b1, 24'h074509, 4'b1010};
      vecs[15] = '{1'b1, 24'h100000, 1'b1, 24'h100000, 4'b0010};

      rst_n = 1'b0;
      mode_12h = 1'b1;
      set_req = 1'b0;
      {set_ht, set_hu, set_mt, set_mu, set_st, set_su} = 24'h0;
`ifdef BCD_CLOCK_ALARM_EN
      {alarm_ht, alarm_hu, alarm_mt, alarm_mu} = 16'h0700;
`endif
      step();
      step();
      check("reset_12h", 24'h120000, 4'b0000);
`ifdef BCD_CLOCK_ALARM_EN
      check_hit("reset_alarm", 1'b0);
`endif
      rst_n = 1'b1;

      // Back-to-back vectors; the prescaler never completes a second between loads.
      for (int i = 0; i < 16; i++) begin
         mode_12h = vecs[i].m12;
         if (vecs[i].req) drive_set(vecs[i].set_t);
         else set_req = 1'b0;
         step();
         check($sformatf("vec%0d", i), vecs[i].exp_t, vecs[i].exp_f);
      end
      set_req = 1'b0;

      // 23:59:58 rolls through midnight, one second per 4 cycles.
      mode_12h = 1'b0;
      drive_set(24'h235958);
      step();
      set_req = 1'b0;
      check("load_235958", 24'h235958, 4'b1010);
      for (int k = 1; k <= 8; k++) begin
         step();
         et = (k < 4) ? 24'h235958 : ((k < 8) ? 24'h235959 : 24'h000000);
         sp = (k == 4) || (k == 8);
         check($sformatf("rollover_c%0d", k), et, {(k < 8), sp, 2'b00});
      end

      // Minute and hour-unit carries.
      drive_set(24'h095959);
      step();
      set_req = 1'b0;
      repeat (4) step();
      check("carry_09_to_10", 24'h100000, 4'b0100);
      drive_set(24'h195959);
      step();
      set_req = 1'b0;
      repeat (4) step();
      check("carry_19_to_20", 24'h200000, 4'b1100);

      // Load landing on the tick cycle discards that tick.
      drive_set(24'h050000);
      step();
      set_req = 1'b0;
      repeat (3) step();
      drive_set(24'h100000);
      step();
      set_req = 1'b0;
      check("set_on_tick", 24'h100000, 4'b0010);
      repeat (3) step();
      check("set_on_tick_wait", 24'h100000, 4'b0000);
      step();
      check("set_on_tick_next", 24'h100001, 4'b0100);

      // set_req held two cycles acts as two requests.
      drive_set(24'h080000);
      step();
      check("held_set_1", 24'h080000, 4'b0010);
      step();
      check("held_set_2", 24'h080000, 4'b0010);
      set_req = 1'b0;

      // Reset beats a coincident load, then counting restarts from prescaler 0.
      step();
      step();
      drive_set(24'h091530);
      rst_n = 1'b0;
      step();
      check("reset_over_set", 24'h000000, 4'b0000);
      rst_n = 1'b1;
      set_req = 1'b0;
      repeat (3) step();
      check("post_reset_wait", 24'h000000, 4'b0000);
      step();
      check("post_reset_tick", 24'h000001, 4'b0100);

`ifdef BCD_CLOCK_ALARM_EN
      drive_set(24'h065959);
      step();
      set_req = 1'b0;
      check_hit("alarm_load_pre", 1'b0);
      repeat (3) step();
      check_hit("alarm_before", 1'b0);
      step();
      check("alarm_time", 24'h070000, 4'b0100);
      check_hit("alarm_fire", 1'b1);
      step();
      check_hit("alarm_one_cycle", 1'b0);
      drive_set(24'h070000);
      step();
      set_req = 1'b0;
      check_hit("alarm_no_load_hit", 1'b0);
      repeat (4) step();
      check("alarm_after_load", 24'h070001, 4'b0100);
      check_hit("alarm_no_hit_01", 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
